dds_sweep_ctrl: RTL
===================

Name: dds_sweep_ctrl

Overview:
- Sequencer that drives the DDS datapath configuration inputs: FTW, amplitude, waveform select and NCO enable.
- Runs a programmed frequency sweep (linear up or down) with dwell per step, optional repeat, and amplitude attack/release ramps around the sweep.
- Sits between the chip-level IO decode and DDS_top. Its outputs feed FTW_IN, amp_in, wavesel_in and enable_in directly.

Parameters:
- W, 6, FTW and config data width
- AW, 6, amplitude width (AW <= W)
- RPT_W, 6, repeat counter width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  config write strobe, sampled on posedge clk
- cfg_addr  in  3  register select: 0 start_ftw, 1 stop_ftw, 2 step, 3 dwell, 4 amp_tgt, 5 {cont, wavesel[1:0]} in data[2:0], 6 repeat
- cfg_data  in  W  config write data
- start  in  1  level-sampled start request
- stop  in  1  abort request
- ftw_out  out  W  to DDS FTW_IN
- amp_out  out  AW  to DDS amp_in
- wavesel_out  out  2  to DDS wavesel_in
- nco_en_out  out  1  to DDS enable_in; low clears NCO phase
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on sweep completion or abort finish

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0. All config regs reset to 0, except dwell=0 and stop_ftw=all-ones.
- Config: a write with cfg_we=1 in IDLE updates the register at the next edge. Writes while busy are ignored. Addr 7 is ignored.
- States: IDLE, RAMP_UP, SWEEP, RAMP_DOWN.
- IDLE to RAMP_UP: start=1 and stop=0. If start and stop are both 1, stay in IDLE. start while busy is ignored.
- Entering RAMP_UP, on the first cycle after start is sampled: nco_en_out=1, ftw_out=start_ftw, wavesel_out=cfg wavesel, amp_out=0. The pass counter is cleared.
- RAMP_UP: amp_out increments by 1 per cycle until it equals amp_tgt, then moves to SWEEP next cycle. If amp_tgt=0, go to SWEEP after one cycle.
- SWEEP: each FTW value is held for dwell+1 cycles.
  - Direction: up if start_ftw <= stop_ftw, otherwise down.
  - Next FTW is ftw ± step, computed W+1 bits wide. It clamps to stop_ftw if it passes stop_ftw, overflows above 2^W-1, or underflows below 0.
  - After stop_ftw has been held for its dwell, that pass is complete.
  - step=0: a single dwell at start_ftw counts as one pass.
  - start_ftw=stop_ftw: one dwell per pass.
- Pass complete:
  - If cont=1, or pass count < repeat: increment the pass count, set ftw_out=start_ftw with no ramp and no enable drop, and stay in SWEEP.
  - Otherwise go to RAMP_DOWN. repeat=N gives N+1 passes.
- RAMP_DOWN: amp_out decrements by 1 per cycle to 0. On the cycle after amp_out reaches 0 the state is IDLE and nco_en_out=0.
  - done=1 for exactly that first IDLE cycle.
  - ftw_out, amp_out and wavesel_out return to 0 in IDLE.
- stop=1 in RAMP_UP or SWEEP: the next state is RAMP_DOWN from the current amp_out. stop during RAMP_DOWN has no effect.
- Mid-operation reset: immediate return to the reset state. No done pulse.
- amp_out never exceeds amp_tgt. Config regs are stable during a run because writes are blocked.

Optional Feature:
- Macro DDS_SWEEP_RAMP_EN.
- Defined: amplitude ramps as described above.
- Undefined:
  - RAMP_UP lasts one cycle with amp_out=amp_tgt.
  - RAMP_DOWN lasts one cycle with amp_out=0, then IDLE.
  - All other timing is unchanged.

Test Plan:
- Reset with outputs forced mid-sweep, then rst_n=0 async → all outputs 0 within the same cycle, busy=0, no done pulse.
- start=10, stop=20, step=4, dwell=1, amp_tgt=3, repeat=0 → amp 0,1,2,3, then ftw 10,10,14,14,18,18,20,20, then amp 3,2,1,0, then IDLE with done=1 for one cycle.
- start=60, stop=5, step=30, dwell=0 → ftw 60,30,5 (clamped); repeat=2 gives exactly 3 passes with no amp dip between passes.
- Up sweep start=50, stop=63, step=20 → overflow clamps ftw to 63; step=0 → a single dwell at 50, then RAMP_DOWN.
- stop asserted on the 3rd SWEEP cycle with amp_tgt=5 → RAMP_DOWN 5..0 and done pulse. start and stop together in IDLE → stays IDLE.
- cfg write of start_ftw=33 while busy → ignored, and the next run uses the old value. With DDS_SWEEP_RAMP_EN undefined, rerun the second scenario → amp steps 0→3 in one cycle and 3→0 in one cycle.

Source files
------------

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl
// Drives the DDS datapath configuration (FTW, amplitude, waveform select and
// NCO enable). In IDLE it accepts register writes. A start request runs an
// amplitude attack, a linear frequency sweep with a per-step dwell and
// optional repeat/continuous passes, and then an amplitude release.
// Build option: define DDS_SWEEP_RAMP_EN to get per-cycle amplitude ramps.
// Without it, the amplitude jumps to its target (attack) or to zero (release)
// in a single cycle. All other timing is the same in both builds.
module dds_sweep_ctrl #(
  parameter int W     = 6,
  parameter int AW    = 6,
  parameter int RPT_W = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [2:0]    cfg_addr,
  input  logic [W-1:0]  cfg_data,
  input  logic          start,
  input  logic          stop,
  output logic [W-1:0]  ftw_out,
  output logic [AW-1:0] amp_out,
  output logic [1:0]    wavesel_out,
  output logic          nco_en_out,
  output logic          busy,
  output logic          done
);

`ifdef DDS_SWEEP_RAMP_EN
  localparam bit RAMP_EN = 1'b1;
`else
  localparam bit RAMP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RAMP_UP   = 2'd1,
    S_SWEEP     = 2'd2,
    S_RAMP_DOWN = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Configuration registers (written only while idle)
  logic [W-1:0]     start_ftw_reg;
  logic [W-1:0]     stop_ftw_reg;
  logic [W-1:0]     step_reg;
  logic [W-1:0]     dwell_reg;
  logic [AW-1:0]    amp_tgt_reg;
  logic             cont_reg;
  logic [1:0]       cfg_ws_reg;
  logic [RPT_W-1:0] rpt_reg;

  // Output and sequencing registers with their next values
  logic [W-1:0]     ftw_reg, ftw_next;
  logic [AW-1:0]    amp_reg, amp_next;
  logic [1:0]       ws_reg, ws_next;
  logic             en_reg, en_next;
  logic             done_reg, done_next;
  logic [W-1:0]     dwell_cnt_reg, dwell_cnt_next;
  logic [RPT_W-1:0] pass_cnt_reg, pass_cnt_next;

  // Sweep arithmetic. The sums are one bit wider so that overflow and
  // underflow are visible in the top bit.
  logic [W:0]   sum_up;
  logic [W:0]   sum_dn;
  logic         dir_up;
  logic         clamp_up;
  logic         clamp_dn;
  logic [W-1:0] ftw_step;
  logic         dwell_done;
  logic         pass_end;
  logic         more_passes;
  logic         amp_at_tgt;
  logic         amp_at_zero;
  logic [AW-1:0] amp_attack;
  logic [AW-1:0] amp_release;

  assign sum_up   = {1'b0, ftw_reg} + {1'b0, step_reg};
  assign sum_dn   = {1'b0, ftw_reg} - {1'b0, step_reg};
  assign dir_up   = (start_ftw_reg <= stop_ftw_reg);
  assign clamp_up = sum_up[W] || (sum_up[W-1:0] > stop_ftw_reg);
  assign clamp_dn = sum_dn[W] || (sum_dn[W-1:0] < stop_ftw_reg);
  assign ftw_step = dir_up ? (clamp_up ? stop_ftw_reg : sum_up[W-1:0])
                           : (clamp_dn ? stop_ftw_reg : sum_dn[W-1:0]);

  assign dwell_done  = (dwell_cnt_reg == dwell_reg);
  // A zero step never leaves start_ftw, so a single dwell there ends the pass.
  assign pass_end    = (ftw_reg == stop_ftw_reg) || (step_reg == '0);
  assign more_passes = cont_reg || (pass_cnt_reg < rpt_reg);
  assign amp_at_tgt  = (amp_reg == amp_tgt_reg);
  assign amp_at_zero = (amp_reg == '0);

  // Amplitude on entry to the attack phase and to the release phase
  assign amp_attack  = RAMP_EN ? '0 : amp_tgt_reg;
  assign amp_release = RAMP_EN ? amp_reg : '0;

  // Configuration register file. Writes are accepted only in IDLE, so the
  // settings stay frozen for the whole run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_ftw_reg <= '0;
      stop_ftw_reg  <= '1;
      step_reg      <= '0;
      dwell_reg     <= '0;
      amp_tgt_reg   <= '0;
      cont_reg      <= 1'b0;
      cfg_ws_reg    <= 2'd0;
      rpt_reg       <= '0;
    end else if (cfg_we && (state_reg == S_IDLE)) begin
      case (cfg_addr)
        3'd0: start_ftw_reg <= cfg_data;
        3'd1: stop_ftw_reg  <= cfg_data;
        3'd2: step_reg      <= cfg_data;
        3'd3: dwell_reg     <= cfg_data;
        3'd4: amp_tgt_reg   <= AW'(cfg_data);
        3'd5: begin
          cont_reg   <= cfg_data[2];
          cfg_ws_reg <= cfg_data[1:0];
        end
        3'd6: rpt_reg       <= RPT_W'(cfg_data);
        default: ;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic. Stop has priority over normal progress and is
  // ignored once the release phase has begun.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start && !stop) state_next = S_RAMP_UP;
      end
      S_RAMP_UP: begin
        if (stop)                       state_next = S_RAMP_DOWN;
        else if (!RAMP_EN || amp_at_tgt) state_next = S_SWEEP;
      end
      S_SWEEP: begin
        if (stop) begin
          state_next = S_RAMP_DOWN;
        end else if (dwell_done && pass_end && !more_passes) begin
          state_next = S_RAMP_DOWN;
        end
      end
      S_RAMP_DOWN: begin
        if (!RAMP_EN || amp_at_zero) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FSM output logic: next values of the DDS controls and of the counters
  always_comb begin
    ftw_next       = ftw_reg;
    amp_next       = amp_reg;
    ws_next        = ws_reg;
    en_next        = en_reg;
    done_next      = 1'b0;
    dwell_cnt_next = dwell_cnt_reg;
    pass_cnt_next  = pass_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (state_next == S_RAMP_UP) begin
          ftw_next      = start_ftw_reg;
          amp_next      = amp_attack;
          ws_next       = cfg_ws_reg;
          en_next       = 1'b1;
          pass_cnt_next = '0;
        end else begin
          ftw_next = '0;
          amp_next = '0;
          ws_next  = 2'd0;
          en_next  = 1'b0;
        end
        dwell_cnt_next = '0;
      end
      S_RAMP_UP: begin
        if (state_next == S_RAMP_DOWN) begin
          amp_next = amp_release;
        end else if (state_next == S_SWEEP) begin
          dwell_cnt_next = '0;
        end else begin
          amp_next = amp_reg + AW'(1);
        end
      end
      S_SWEEP: begin
        if (state_next == S_RAMP_DOWN) begin
          amp_next = amp_release;
        end else if (dwell_done) begin
          dwell_cnt_next = '0;
          if (pass_end) begin
            // A new pass restarts at start_ftw with no ramp and no enable drop
            pass_cnt_next = pass_cnt_reg + RPT_W'(1);
            ftw_next      = start_ftw_reg;
          end else begin
            ftw_next = ftw_step;
          end
        end else begin
          dwell_cnt_next = dwell_cnt_reg + W'(1);
        end
      end
      S_RAMP_DOWN: begin
        if (state_next == S_IDLE) begin
          ftw_next  = '0;
          amp_next  = '0;
          ws_next   = 2'd0;
          en_next   = 1'b0;
          done_next = 1'b1;
        end else begin
          amp_next = amp_reg - AW'(1);
        end
      end
      default: ;
    endcase
  end

  // Registered DDS controls and sequencing counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ftw_reg       <= '0;
      amp_reg       <= '0;
      ws_reg        <= 2'd0;
      en_reg        <= 1'b0;
      done_reg      <= 1'b0;
      dwell_cnt_reg <= '0;
      pass_cnt_reg  <= '0;
    end else begin
      ftw_reg       <= ftw_next;
      amp_reg       <= amp_next;
      ws_reg        <= ws_next;
      en_reg        <= en_next;
      done_reg      <= done_next;
      dwell_cnt_reg <= dwell_cnt_next;
      pass_cnt_reg  <= pass_cnt_next;
    end
  end

  assign ftw_out     = ftw_reg;
  assign amp_out     = amp_reg;
  assign wavesel_out = ws_reg;
  assign nco_en_out  = en_reg;
  assign busy        = (state_reg != S_IDLE);
  assign done        = done_reg;

endmodule
